// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: index width, default dwell width
// and the controller state encoding.
package scan_pkg;

    localparam int IDX_W           = 4;
    localparam int DEFAULT_DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_sequencer_dwell_counter.sv
// Loadable down-counter that flags its terminal count (value of one or less).
// It stops at one, so a clamped non-zero load can never underflow.
module dwell_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_decrement,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_decrement && (r_count > WIDTH'(1))) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_terminal = (r_count <= WIDTH'(1));

endmodule

// File: rtl/scan_sequencer.sv
// Drives a 4-to-16 one-hot decoder through a programmable index range,
// holding each index for a dwell time with one blank cycle between indices.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = DEFAULT_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [IDX_W-1:0]   first_idx,
    input  logic [IDX_W-1:0]   last_idx,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               continuous,
    output logic               dec_enable,
    output logic [IDX_W-1:0]   dec_index,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    scan_state_t        r_state;
    scan_state_t        w_nextState;
    logic [IDX_W-1:0]   r_firstIdx;
    logic [IDX_W-1:0]   r_lastIdx;
    logic [IDX_W-1:0]   r_decIndex;
    logic [IDX_W-1:0]   w_nextIndex;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_startDwell;
    logic [DWELL_W-1:0] w_loadValue;
    logic               r_continuous;
    logic               r_done;
    logic               r_wrap;
    logic               w_nextDone;
    logic               w_nextWrap;
    logic               w_accept;
    logic               w_load;
    logic               w_decrement;
    logic               w_terminal;

    // A dwell of zero behaves as one so every index is shown at least once.
    assign w_startDwell = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_accept     = (r_state == ST_IDLE) && start && !stop;
    assign w_loadValue  = w_accept ? w_startDwell : r_dwell;

    dwell_counter #(
        .WIDTH(DWELL_W)
    ) u_dwellCounter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_loadValue(w_loadValue),
        .i_decrement(w_decrement),
        .o_terminal (w_terminal)
    );

    always_comb begin
        w_nextState = r_state;
        w_nextIndex = r_decIndex;
        w_nextDone  = 1'b0;
        w_nextWrap  = 1'b0;
        w_load      = 1'b0;
        w_decrement = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = ST_DWELL;
                    w_nextIndex = first_idx;
                    w_load      = 1'b1;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    w_nextState = ST_IDLE;
                end else if (!w_terminal) begin
                    w_decrement = 1'b1;
                end else if (r_decIndex != r_lastIdx) begin
                    w_nextState = ST_BLANK;
                end else if (r_continuous) begin
                    w_nextState = ST_BLANK;
                    w_nextWrap  = 1'b1;
                end else begin
                    w_nextState = ST_IDLE;
                    w_nextDone  = 1'b1;
                end
            end
            ST_BLANK: begin
                // A wrap blank restarts the range; any other blank steps mod 16.
                if (stop) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_nextState = ST_DWELL;
                    w_load      = 1'b1;
                    w_nextIndex = r_wrap ? r_firstIdx : r_decIndex + IDX_W'(1);
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_decIndex   <= '0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
            r_firstIdx   <= '0;
            r_lastIdx    <= '0;
            r_dwell      <= '0;
            r_continuous <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_decIndex <= w_nextIndex;
            r_done     <= w_nextDone;
            r_wrap     <= w_nextWrap;
            if (w_accept) begin
                r_firstIdx   <= first_idx;
                r_lastIdx    <= last_idx;
                r_dwell      <= w_startDwell;
                r_continuous <= continuous;
            end
        end
    end

    assign dec_enable = (r_state == ST_DWELL);
    assign busy       = (r_state != ST_IDLE);
    assign dec_index  = r_decIndex;
    assign done       = r_done;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench: a queue of expected per-cycle outputs built from the
// range/dwell rules is compared against the sequencer on every falling edge.
module tb_scan_sequencer;

    typedef struct {
        logic       en;
        logic [3:0] idx;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] first_idx = '0;
    logic [3:0] last_idx = '0;
    logic [7:0] dwell = '0;
    logic       continuous = 1'b0;
    logic       dec_enable;
    logic [3:0] dec_index;
    logic       busy;
    logic       done;
    logic       wrap;

    exp_t       expQ[$];
    exp_t       cmpEntry;
    logic [3:0] heldIdx = '0;
    bit         checking = 1'b0;
    bit         prevEn = 1'b0;
    int         assertions = 0;
    int         failures = 0;
    int         cyc = 0;
    int         enCount = 0;
    int         busyCount = 0;
    int         doneCycle = 0;
    int         doneCount = 0;
    int         wrapCount = 0;
    int         visited[$];

    scan_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .dwell     (dwell),
        .continuous(continuous),
        .dec_enable(dec_enable),
        .dec_index (dec_index),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Expected trace: each index held D cycles, a blank between indices, and
    // the pass ending in either a done cycle or a wrap blank.
    task automatic pushScan(input int first, input int last, input int dw, input bit cont, input int passes);
        int d = (dw == 0) ? 1 : dw;
        int n = ((last - first) & 15) + 1;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < n; k++) begin
                logic [3:0] idx = 4'((first + k) & 15);
                for (int c = 0; c < d; c++)
                    expQ.push_back('{en:1'b1, idx:idx, busy:1'b1, done:1'b0, wrap:1'b0});
                if (k < n - 1)
                    expQ.push_back('{en:1'b0, idx:idx, busy:1'b1, done:1'b0, wrap:1'b0});
                else if (cont)
                    expQ.push_back('{en:1'b0, idx:idx, busy:1'b1, done:1'b0, wrap:1'b1});
                else
                    expQ.push_back('{en:1'b0, idx:idx, busy:1'b0, done:1'b1, wrap:1'b0});
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (expQ.size() > 0)
                cmpEntry = expQ.pop_front();
            else
                cmpEntry = '{en:1'b0, idx:heldIdx, busy:1'b0, done:1'b0, wrap:1'b0};
            heldIdx = cmpEntry.idx;
            checkOutput("dec_enable", int'(dec_enable), int'(cmpEntry.en));
            checkOutput("dec_index", int'(dec_index), int'(cmpEntry.idx));
            checkOutput("busy", int'(busy), int'(cmpEntry.busy));
            checkOutput("done", int'(done), int'(cmpEntry.done));
            checkOutput("wrap", int'(wrap), int'(cmpEntry.wrap));
            cyc++;
            if (dec_enable) begin
                enCount++;
                if (!prevEn) visited.push_back(int'(dec_index));
            end
            prevEn = dec_enable;
            if (busy) busyCount++;
            if (done) begin
                doneCount++;
                if (doneCycle == 0) doneCycle = cyc;
            end
            if (wrap) wrapCount++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic applyStimulus(input int first, input int last, input int dw, input bit cont, input int passes);
        @(posedge clk); #2;
        first_idx  = 4'(first);
        last_idx   = 4'(last);
        dwell      = 8'(dw);
        continuous = cont;
        start      = 1'b1;
        @(posedge clk); #2;
        start     = 1'b0;
        cyc       = 0;
        enCount   = 0;
        busyCount = 0;
        doneCycle = 0;
        doneCount = 0;
        wrapCount = 0;
        prevEn    = 1'b0;
        visited.delete();
        pushScan(first, last, dw, cont, passes);
    endtask

    task automatic stopScan();
        @(posedge clk); #2;
        stop = 1'b1;
        @(posedge clk); #2;
        stop = 1'b0;
        expQ.delete();
    endtask

    task automatic resetPulse();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        expQ.delete();
        heldIdx = '0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset dec_enable", int'(dec_enable), 0);
        checkOutput("reset dec_index", int'(dec_index), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset wrap", int'(wrap), 0);
        rst      = 1'b0;
        heldIdx  = '0;
        checking = 1'b1;

        // Range 2..4, dwell 3; config inputs then wander without a start.
        applyStimulus(2, 4, 3, 1'b0, 1);
        waitCycles(2);
        first_idx  = 4'd9;
        last_idx   = 4'd9;
        dwell      = 8'd7;
        continuous = 1'b1;
        waitCycles(12);
        settle();
        checkOutput("t1 done cycle", doneCycle, 12);
        checkOutput("t1 busy cycles", busyCount, 11);
        checkOutput("t1 enable cycles", enCount, 9);
        checkOutput("t1 done pulses", doneCount, 1);

        // Wrap through 15 to 0 with single-cycle dwells.
        applyStimulus(14, 1, 1, 1'b0, 1);
        waitCycles(9);
        settle();
        checkOutput("t2 busy cycles", busyCount, 7);
        checkOutput("t2 enable cycles", enCount, 4);
        checkOutput("t2 done cycle", doneCycle, 8);
        checkOutput("t2 visit count", visited.size(), 4);
        if (visited.size() == 4) begin
            checkOutput("t2 visit0", visited[0], 14);
            checkOutput("t2 visit1", visited[1], 15);
            checkOutput("t2 visit2", visited[2], 0);
            checkOutput("t2 visit3", visited[3], 1);
        end

        // Zero dwell is clamped to one.
        applyStimulus(5, 5, 0, 1'b0, 1);
        waitCycles(3);
        settle();
        checkOutput("t3 enable cycles", enCount, 1);
        checkOutput("t3 busy cycles", busyCount, 1);
        checkOutput("t3 done cycle", doneCycle, 2);

        // Continuous 0..1 dwell 2, with an ignored start while busy.
        applyStimulus(0, 1, 2, 1'b1, 4);
        waitCycles(3);
        @(posedge clk); #2;
        first_idx = 4'd8;
        last_idx  = 4'd12;
        dwell     = 8'd5;
        start     = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        waitCycles(13);
        settle();
        checkOutput("t4 wrap pulses", wrapCount, 3);
        checkOutput("t4 done pulses", doneCount, 0);
        stopScan();
        waitCycles(2);

        // Stop in the middle of the first dwell at index 3.
        applyStimulus(3, 6, 4, 1'b0, 1);
        stopScan();
        settle();
        checkOutput("t5 enable after stop", int'(dec_enable), 0);
        checkOutput("t5 busy after stop", int'(busy), 0);
        checkOutput("t5 index after stop", int'(dec_index), 3);
        waitCycles(3);
        settle();
        checkOutput("t5 done pulses", doneCount, 0);

        // Reset in the middle of a continuous scan.
        applyStimulus(7, 9, 2, 1'b1, 3);
        waitCycles(2);
        resetPulse();
        settle();
        checkOutput("t6 enable after reset", int'(dec_enable), 0);
        checkOutput("t6 index after reset", int'(dec_index), 0);
        checkOutput("t6 busy after reset", int'(busy), 0);
        checkOutput("t6 wrap after reset", int'(wrap), 0);

        // Start together with stop in IDLE is refused.
        @(posedge clk); #2;
        first_idx = 4'd4;
        last_idx  = 4'd6;
        dwell     = 8'd2;
        start     = 1'b1;
        stop      = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        stop  = 1'b0;
        settle();
        checkOutput("t7 busy", int'(busy), 0);
        checkOutput("t7 enable", int'(dec_enable), 0);
        waitCycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
